// File: rtl/bistable_state_capture.sv
// -----------------------------------------------------------------------------
// bistable_state_capture
//
// Clocked consumer of the complementary w1/w2 node pair from a free-running
// cross-coupled-inverter bistable. Both rails are synchronized into the clk
// domain, qualified as a legal complementary pair, debounced, and reported as
// a registered state with one-cycle change pulses. Persistent both-equal
// (illegal) conditions are flagged and counted once per episode.
//
// Parameters:
//   SYNC_STAGES    synchronizer flops per rail (>= 2)
//   STABLE_CYCLES  consecutive identical qualified samples to accept a value
//                  or to declare an illegal episode (>= 2)
//   CNT_W          width of the illegal-episode counter
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   w1_in        bistable rail 1 (asynchronous to clk)
//   w2_in        bistable rail 2 (asynchronous to clk)
//   err_clr      one-cycle synchronous clear of illegal_err / illegal_cnt
//   state_q      accepted bistable value (w1 of the last qualified pair)
//   state_valid  high while the FSM is in STABLE
//   rise_pulse   one-cycle pulse on a 0->1 change of state_q within STABLE
//   fall_pulse   one-cycle pulse on a 1->0 change of state_q within STABLE
//   illegal_err  sticky flag, set on every entry to ILLEGAL
//   illegal_cnt  number of ILLEGAL entries, saturating at all-ones
// -----------------------------------------------------------------------------
module bistable_state_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w1_in,
    input  logic             w2_in,
    input  logic             err_clr,
    output logic             state_q,
    output logic             state_valid,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             illegal_err,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0]  RUN_MAX = SC_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_STABLE  = 2'd1;
    localparam logic [1:0] ST_ILLEGAL = 2'd2;

    logic [SYNC_STAGES-1:0] w1_sync;
    logic [SYNC_STAGES-1:0] w2_sync;
    logic                   w1_s;
    logic                   w2_s;
    logic                   sample_legal;

    logic [1:0]      fsm;
    logic            cand;
    logic            cand_next;
    logic [SC_W-1:0] sc;
    logic [SC_W-1:0] sc_next;
    logic [SC_W-1:0] ic;
    logic [SC_W-1:0] ic_next;

    logic acquire;
    logic change;
    logic enter_illegal;

    // -------------------------------------------------------------------------
    // Per-rail synchronizers. Each rail is synchronized independently, so rail
    // skew shows up as a short illegal or differing run that the debounce
    // below absorbs.
    // -------------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_sync <= '0;
            w2_sync <= '0;
        end else begin
            w1_sync <= {w1_sync[SYNC_STAGES-2:0], w1_in};
            w2_sync <= {w2_sync[SYNC_STAGES-2:0], w2_in};
        end
    end

    assign w1_s         = w1_sync[SYNC_STAGES-1];
    assign w2_s         = w2_sync[SYNC_STAGES-1];
    assign sample_legal = w1_s ^ w2_s;

    // -------------------------------------------------------------------------
    // Settle counter / candidate and illegal run counter. Both saturate at
    // STABLE_CYCLES; decisions are taken on the edge where the *next* value
    // reaches the limit, so the outputs move on that same edge.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a signal unassigned (no latch inferred).
    always_comb begin
        cand_next = cand;
        sc_next   = sc;
        ic_next   = ic;
        if (sample_legal) begin
            ic_next = '0;
            if (w1_s == cand) begin
                sc_next = (sc == RUN_MAX) ? sc : sc + SC_W'(1);
            end else begin
                cand_next = w1_s;
                sc_next   = SC_W'(1);
            end
        end else begin
            sc_next = '0;
            ic_next = (ic == RUN_MAX) ? ic : ic + SC_W'(1);
        end
    end

    // A saturated settle counter in STABLE with cand == state_q is the steady
    // case and must not produce a pulse; only a differing candidate does.
    assign acquire       = (sc_next == RUN_MAX) && (fsm != ST_STABLE);
    assign change        = (sc_next == RUN_MAX) && (fsm == ST_STABLE) && (cand_next != state_q);
    // Staying in ILLEGAL with ic saturated is one episode, counted once.
    assign enter_illegal = (ic_next == RUN_MAX) && (fsm != ST_ILLEGAL);

    // -------------------------------------------------------------------------
    // FSM, registered state and pulses, error bookkeeping.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= ST_UNKNOWN;
            cand        <= 1'b0;
            sc          <= '0;
            ic          <= '0;
            state_q     <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            illegal_err <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            cand <= cand_next;
            sc   <= sc_next;
            ic   <= ic_next;

            // Acquisition sets state_q silently; only a change within STABLE
            // is reported as an edge.
            if (acquire || change) begin
                state_q <= cand_next;
            end
            rise_pulse <= change && cand_next;
            fall_pulse <= change && !cand_next;

            // acquire and enter_illegal are mutually exclusive: one needs a
            // legal sample, the other an illegal one.
            if (acquire) begin
                fsm <= ST_STABLE;
            end else if (enter_illegal) begin
                fsm <= ST_ILLEGAL;
            end

            // An entry on the same edge as err_clr wins and counts as the
            // first episode after the clear.
            if (enter_illegal) begin
                illegal_err <= 1'b1;
                if (err_clr) begin
                    illegal_cnt <= CNT_W'(1);
                end else if (illegal_cnt != CNT_MAX) begin
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
                end
            end else if (err_clr) begin
                illegal_err <= 1'b0;
                illegal_cnt <= '0;
            end
        end
    end

    assign state_valid = (fsm == ST_STABLE);

endmodule

// File: tb/tb_bistable_state_capture.sv
// -----------------------------------------------------------------------------
// tb_bistable_state_capture
//
// Self-checking bench for bistable_state_capture. A behavioural model keeps a
// history of driven rail pairs, derives the qualified sample seen SYNC_STAGES
// edges later, and decides acceptance / illegal episodes from a sliding window
// of the last STABLE_CYCLES samples. Directed scenarios add fixed-latency
// expectations on top of the model comparison.
// -----------------------------------------------------------------------------
module tb_bistable_state_capture;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 8;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             w1_in = 1'b1;
    logic             w2_in = 1'b0;
    logic             err_clr = 1'b0;
    logic             state_q;
    logic             state_valid;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             illegal_err;
    logic [CNT_W-1:0] illegal_cnt;

    bistable_state_capture #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w1_in      (w1_in),
        .w2_in      (w2_in),
        .err_clr    (err_clr),
        .state_q    (state_q),
        .state_valid(state_valid),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .illegal_err(illegal_err),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------------------------------------------------------- model
    typedef enum {M_UNKNOWN, M_STABLE, M_ILLEGAL} mstate_t;

    logic [1:0]       hist[$];   // driven {w1,w2} at recent edges
    logic [1:0]       samp[$];   // last STABLE_CYCLES qualified samples
    mstate_t          m_state;
    logic             m_q;
    logic             m_rise;
    logic             m_fall;
    logic             m_err;
    logic [CNT_W-1:0] m_cnt;

    logic [CNT_W+4:0] act_vec;
    assign act_vec = {state_valid, state_q, rise_pulse, fall_pulse, illegal_err, illegal_cnt};

    function automatic logic [CNT_W+4:0] model_vec();
        return {m_state == M_STABLE, m_q, m_rise, m_fall, m_err, m_cnt};
    endfunction

    task automatic model_reset();
        hist.delete();
        samp.delete();
        m_state = M_UNKNOWN;
        m_q     = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
    endtask

    // Called once per rising edge, with the inputs as they were at that edge.
    task automatic model_step();
        logic [1:0] s;
        bit         legal_run;
        bit         illegal_run;
        bit         entry;
        logic       v;
        hist.push_back({w1_in, w2_in});
        if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_front());
        // Before the synchronizers have filled, the sample is the reset value 00.
        s = (hist.size() > SYNC_STAGES) ? hist[0] : 2'b00;
        samp.push_back(s);
        if (samp.size() > STABLE_CYCLES) void'(samp.pop_front());

        legal_run   = (samp.size() == STABLE_CYCLES);
        illegal_run = (samp.size() == STABLE_CYCLES);
        foreach (samp[i]) begin
            if (samp[i][1] == samp[i][0]) legal_run = 0;
            else illegal_run = 0;
            if (samp[i][1] != samp[0][1]) legal_run = 0;
        end

        m_rise = 1'b0;
        m_fall = 1'b0;
        entry  = 0;
        if (legal_run) begin
            v = samp[0][1];
            if (m_state != M_STABLE) begin
                m_state = M_STABLE;
                m_q     = v;
            end else if (v != m_q) begin
                m_rise = v;
                m_fall = !v;
                m_q    = v;
            end
        end else if (illegal_run && m_state != M_ILLEGAL) begin
            m_state = M_ILLEGAL;
            entry   = 1;
        end

        if (entry) begin
            m_err = 1'b1;
            if (err_clr) m_cnt = 1;
            else if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
        end else if (err_clr) begin
            m_err = 1'b0;
            m_cnt = '0;
        end
    endtask

    // Advance one edge, update the model, and return at the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n   = 1'b0;
        w1_in   = 1'b1;
        w2_in   = 1'b0;
        err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs act=%h exp=0", act_vec);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_acquire();
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL acquire_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
            n_checks++;
            if ({state_valid, state_q, rise_pulse, illegal_cnt} !==
                {e >= LAT, e >= LAT, 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL acquire_latency e=%0d valid=%b q=%b rise=%b cnt=%0d exp_valid=%0d",
                         e, state_valid, state_q, rise_pulse, illegal_cnt, e >= LAT);
            end
        end
    endtask

    task automatic test_flip();
        w1_in = 1'b0;
        w2_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL flip_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
            n_checks++;
            if ({state_valid, state_q, fall_pulse, rise_pulse} !==
                {1'b1, e < LAT, e == LAT, 1'b0}) begin
                n_fail++;
                $display("FAIL flip_fall e=%0d valid=%b q=%b fall=%b rise=%b",
                         e, state_valid, state_q, fall_pulse, rise_pulse);
            end
        end
    endtask

    task automatic test_glitch();
        w1_in = 1'b1;
        w2_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 2) begin
                w1_in = 1'b0;
                w2_in = 1'b1;
            end
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL glitch_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
            n_checks++;
            if (act_vec !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL glitch_hold e=%0d act=%h exp=%h", e, act_vec,
                         {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
            end
        end
    endtask

    task automatic test_illegal_hold();
        w1_in = 1'b0;
        w2_in = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL illegal_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
            n_checks++;
            if ({state_valid, state_q, illegal_err, illegal_cnt} !==
                {e < LAT, 1'b0, e >= LAT, (e >= LAT) ? 8'd1 : 8'd0}) begin
                n_fail++;
                $display("FAIL illegal_entry e=%0d valid=%b err=%b cnt=%0d",
                         e, state_valid, illegal_err, illegal_cnt);
            end
        end
        w1_in = 1'b1;
        w2_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL recover_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
            n_checks++;
            if ({state_valid, state_q, rise_pulse, fall_pulse} !==
                {e >= LAT, e >= LAT, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL recover_acquire e=%0d valid=%b q=%b rise=%b fall=%b",
                         e, state_valid, state_q, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_episodes();
        for (int k = 0; k < 2; k++) begin
            for (int e = 1; e <= 16; e++) begin
                w1_in = (e > 8);
                w2_in = 1'b0;
                step();
                n_checks++;
                if (act_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL episode_model k=%0d e=%0d act=%h exp=%h", k, e, act_vec, model_vec());
                end
            end
        end
        n_checks++;
        if ({illegal_err, illegal_cnt} !== {1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL episode_count err=%b cnt=%0d exp_cnt=3", illegal_err, illegal_cnt);
        end

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if ({state_valid, state_q, illegal_err, illegal_cnt} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL err_clr valid=%b q=%b err=%b cnt=%0d", state_valid, state_q,
                     illegal_err, illegal_cnt);
        end

        // One more episode, then an entry coinciding with err_clr.
        for (int e = 1; e <= 16; e++) begin
            w1_in = 1'b1;
            w2_in = (e <= 8);
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL episode4_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
        end
        w1_in = 1'b1;
        w2_in = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            err_clr = (e == LAT);
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL clr_entry_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
        end
        err_clr = 1'b0;
        n_checks++;
        if ({state_valid, illegal_err, illegal_cnt} !== {1'b0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL clr_entry valid=%b err=%b cnt=%0d exp_cnt=1", state_valid,
                     illegal_err, illegal_cnt);
        end
        w1_in = 1'b1;
        w2_in = 1'b0;
        repeat (8) step();
        n_checks++;
        if (act_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reacquire_model act=%h exp=%h", act_vec, model_vec());
        end
    endtask

    task automatic test_async_reset();
        w1_in = 1'b0;
        w2_in = 1'b1;
        repeat (5) step();   // settle counter now at 3
        n_checks++;
        if (act_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL pre_reset_model act=%h exp=%h", act_vec, model_vec());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act_vec !== '0) begin
            n_fail++;
            $display("FAIL async_reset act=%h exp=0", act_vec);
        end
        @(negedge clk);
        w1_in = 1'b1;
        w2_in = 1'b0;
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (act_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL post_reset_model e=%0d act=%h exp=%h", e, act_vec, model_vec());
            end
            n_checks++;
            if ({state_valid, state_q, rise_pulse, illegal_err} !==
                {e >= LAT, e >= LAT, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL post_reset_acquire e=%0d valid=%b q=%b rise=%b err=%b",
                         e, state_valid, state_q, rise_pulse, illegal_err);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int cyc;
        cyc = 0;
        while (cyc < 400) begin
            {w1_in, w2_in} = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                err_clr = ($urandom_range(0, 15) == 0);
                step();
                cyc++;
                n_checks++;
                if (act_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL random_model cyc=%0d act=%h exp=%h", cyc, act_vec, model_vec());
                end
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_flip();
        test_glitch();
        test_illegal_hold();
        test_episodes();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
